// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types and constants for the nibble-serial add/subtract block
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// rtl/nibble_serial_addsub_if.sv - request/response bundle for the nibble-serial add/subtract block
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, mode, cin, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, mode, cin, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );

endinterface

// File: rtl/four_bit_RCA_RCS.sv
// rtl/four_bit_RCA_RCS.sv - 4-bit ripple-carry adder/subtractor slice (mode=1 inverts b and forces carry-in)
module four_bit_RCA_RCS (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] bx;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;

    assign bx = b ^ {4{mode}};
    assign c0 = cin | mode;

    assign sum[0] = a[0] ^ bx[0] ^ c0;
    assign c1     = (a[0] & bx[0]) | (c0 & (a[0] ^ bx[0]));
    assign sum[1] = a[1] ^ bx[1] ^ c1;
    assign c2     = (a[1] & bx[1]) | (c1 & (a[1] ^ bx[1]));
    assign sum[2] = a[2] ^ bx[2] ^ c2;
    assign c3     = (a[2] & bx[2]) | (c2 & (a[2] ^ bx[2]));
    assign sum[3] = a[3] ^ bx[3] ^ c3;
    assign cout   = (a[3] & bx[3]) | (c3 & (a[3] ^ bx[3]));

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - nibble-serial add/subtract, LS nibble first; flags gated by NIBBLE_SERIAL_ADDSUB_FLAGS_EN
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBS  = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bn_q, bn_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] bn_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign a_nib  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign bn_nib = bn_q[idx_q*NIBBLE_W +: NIBBLE_W];

    // b is stored already inverted for subtract, so the slice always adds and the carry register owns carry-in
    four_bit_RCA_RCS u_slice (
        .a    (a_nib),
        .b    (bn_nib),
        .mode (1'b0),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
    logic overflow_q, overflow_d;
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        bn_d        = bn_q;
        result_d    = result_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
        overflow_d  = overflow_q;
        zero_d      = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    bn_d       = mode ? ~b : b;
                    carry_d    = mode ? 1'b1 : cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
                    // sign-rule form of carry-into-MSB XOR carry-out
                    overflow_d  = (a_nib[NIBBLE_W-1] ~^ bn_nib[NIBBLE_W-1])
                                & (slice_sum[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1]);
                    zero_d      = (result_d == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            bn_q        <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            bn_q        <= bn_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;

`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
    assign overflow = overflow_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects add, 1 selects subtract (a-b).
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in, used in add mode only.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the sum or difference.
REQ-012 The block SHALL have port cout, output, 1 bit: the final carry; in subtract mode 1 means no borrow.
REQ-013 The block SHALL have ports overflow and zero, output, 1 bit each: signed overflow, and result equal to 0.

Function
REQ-014 The block SHALL compute the full-width result 4 bits per cycle through one 4-bit add/subtract slice, least-significant nibble first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-017 On an edge where in_valid=1 and in_ready=1 (acceptance), the block SHALL latch a, b, mode and cin, clear the nibble index, and enter RUN.
REQ-018 Each RUN cycle SHALL add nibble idx of a to nibble idx of b (b inverted when mode=1), with the registered carry as carry-in.
REQ-019 At each RUN edge the block SHALL store that nibble into result[idx], store the slice carry-out, and increment idx.
REQ-020 The carry-in to nibble 0 SHALL be cin when mode=0 and 1 when mode=1.
REQ-021 After the edge that stores nibble WIDTH/4-1, the block SHALL enter DONE with out_valid=1. An acceptance at edge t therefore gives out_valid high from edge t+WIDTH/4.
REQ-022 cout SHALL equal the carry-out of the last nibble.
REQ-023 overflow SHALL equal the carry into the MSB XOR cout.
REQ-024 zero SHALL be 1 when result equals 0.
REQ-025 In DONE, result, cout, overflow and zero SHALL hold stable while out_ready=0.
REQ-026 In DONE, the block SHALL ignore in_valid.
REQ-027 On an edge in DONE with out_ready=1, the block SHALL return to IDLE and deassert out_valid. A new request is accepted no earlier than the following edge.
REQ-028 out_valid SHALL never be 1 in IDLE or RUN.
REQ-029 Changes on a, b, mode and cin after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-030 While rst_n=0, the block SHALL hold state IDLE, in_ready=1, out_valid=0, result=0, cout=0, overflow=0, zero=0, idx=0, and the carry register at 0.
REQ-031 Assertion of rst_n in RUN or DONE SHALL abort the operation immediately. No result SHALL be presented after reset release.

Configuration
REQ-032 The macro NIBBLE_SERIAL_ADDSUB_FLAGS_EN SHALL control flag generation.
REQ-033 With NIBBLE_SERIAL_ADDSUB_FLAGS_EN defined, overflow and zero SHALL behave as in REQ-023 and REQ-024.
REQ-034 Without NIBBLE_SERIAL_ADDSUB_FLAGS_EN, the ports SHALL remain present and tied to 0, and no flag logic SHALL be generated.

Structure
REQ-035 A package nibble_serial_addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIBBLE_W=4.
REQ-036 The slice SHALL be the team's existing four_bit_RCA_RCS adder/subtractor instantiated once, driven with mode=0 and pre-inverted b, so the block controls the carry-in directly.
REQ-037 The block SHALL contain no other sub-module.

Verification (WIDTH=16, flags enabled)
REQ-038 Add 0x1234 + 0x0FFF, cin=0: out_valid SHALL rise 4 cycles after acceptance with result=0x2233, cout=0, overflow=0, zero=0.
REQ-039 Add 0xFFFF + 0x0001, cin=0: result SHALL be 0x0000, cout=1, zero=1, overflow=0.
REQ-040 Add 0x7FFF + 0x0000, cin=1: result SHALL be 0x8000, overflow=1, cout=0.
REQ-041 Subtract 0x0005 - 0x0007, cin=1: result SHALL be 0xFFFE, cout=0, overflow=0, because cin is ignored in subtract mode.
REQ-042 Subtract 0x8000 - 0x0001 with out_ready held low for 3 cycles and in_valid=1 throughout: result SHALL be 0x7FFF, overflow=1, cout=1, held for all 3 cycles; in_ready SHALL stay 0; the new request SHALL be accepted only on the edge after the edge where out_ready=1 is sampled.
REQ-043 Assert rst_n=0 during the second RUN cycle: all outputs SHALL be at their reset values; after release, in_ready=1 and out_valid SHALL stay 0 until a new request completes.
